mac_unit: RTL and testbench
===========================

Name: mac_unit

Overview:
- Unsigned multiply-accumulate block.
- Every rising clock edge outside reset, multiplies two operand inputs and adds the product into an internal accumulator register.
- The registered accumulator is the primary output.
- Serves as a datapath primitive for filter/dot-product pipelines. Single clock domain.

Parameters:
- DATA_W, 8, width of each unsigned operand a and b.
- ACC_W, 16, width of accumulator register and acc output; must be >= 2*DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  DATA_W  unsigned multiplicand, sampled every rising edge.
- b  input  DATA_W  unsigned multiplier, sampled every rising edge.
- acc  output  ACC_W  registered accumulator value.
- ovf  output  1  sticky overflow flag; set when an accumulation wraps past 2^ACC_W-1.

Behaviour:
- Reset: rst high forces acc = 0 and ovf = 0 immediately, without waiting for a clock edge. Both are held at 0 while rst stays high, regardless of a, b or clk.
- Reset release: the first rising edge with rst low performs an accumulation. No dead cycle after reset.
- Accumulate, each rising edge with rst low:
  - prod = a * b, unsigned, full 2*DATA_W bits.
  - acc <= acc + zero-extended prod, computed modulo 2^ACC_W.
- Latency: the product of a/b sampled at edge N is visible on acc immediately after edge N, one register stage. Product and sum are combinational ahead of the register. No internal pipelining.
- No enable or clear input. Accumulation occurs on every non-reset edge. Constant nonzero inputs keep growing acc; a=0 or b=0 holds acc unchanged.
- Overflow: if acc + prod >= 2^ACC_W, acc takes the wrapped value and ovf is set to 1. ovf stays 1 until the next reset.
- Width rule: max product (2^DATA_W-1)^2 = 65025 fits in ACC_W=16. Only the running sum can overflow.
- Reset mid-operation: an asynchronous assertion between edges clears acc/ovf at once. The pending accumulation is discarded.
- Reset and edge together: rst has priority; acc stays 0.
- X/undriven operands outside reset are not required to be handled. The bench always drives known values.
- Outputs are driven only by flops; no combinational path from a/b to acc or ovf.

Decomposition:
- Package mac_pkg: localparams DATA_W=8 and ACC_W=16, plus typedefs operand_t [DATA_W-1:0], product_t [2*DATA_W-1:0], acc_t [ACC_W-1:0].
- One sub-module: mac_mult, a combinational unsigned shift-and-add array multiplier (DATA_W x DATA_W -> 2*DATA_W) built from explicit partial-product rows and a generate-based adder chain. No behavioural '*' operator.
- Top level mac_unit instantiates mac_mult and holds:
  - the ACC_W+1-bit adder; the carry-out drives overflow detection;
  - the accumulator and ovf flops with async reset.

Test Plan:
- Reset then accumulate: rst=1, a=b=0 for 10 time units -> acc=0. Release rst with a=2,b=4 -> acc=8 after first edge. a=4,b=4 -> 24. a=3,b=5 -> 39, and 54 after a further edge with inputs held.
- Async reset mid-run: accumulate to a nonzero value, pulse rst between clock edges -> acc and ovf drop to 0 before the next edge. The following edge with a=1,b=1 gives acc=1.
- Zero operand hold: after acc=24, drive a=0,b=200 for 5 edges -> acc stays 24.
- Max product: from reset, a=255,b=255 for one edge -> acc=65025, ovf=0.
- Overflow wrap: acc=65025, then a=255,b=2 (510) -> acc=(65025+510) mod 65536=65535-? i.e. 65535 exact, ovf=0. Then a=1,b=1 -> acc=0, ovf=1. Further accumulations keep ovf=1 until rst.
- Random regression: 1000 cycles of random a/b with occasional async rst pulses, checked against a modulo-2^16 reference model of acc plus a sticky overflow reference.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths and types for the multiply-accumulate block.
//   DATA_W : width of each unsigned operand
//   ACC_W  : width of the accumulator (must be >= 2*DATA_W)
package mac_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef logic [DATA_W-1:0]   operand_t;
  typedef logic [2*DATA_W-1:0] product_t;
  typedef logic [ACC_W-1:0]    acc_t;

endpackage

// File: rtl/mac_mult.sv
// Combinational unsigned shift-and-add array multiplier.
// Ports:
//   a    : unsigned multiplicand, DATA_W bits
//   b    : unsigned multiplier, DATA_W bits
//   prod : full-width product a*b, 2*DATA_W bits
// Each bit of b gates a copy of a shifted into its weight position; the rows
// are summed by a linear chain of adders.
module mac_mult #(
  parameter int DATA_W = mac_pkg::DATA_W
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] prod
);
  import mac_pkg::*;

  localparam int PW = 2 * DATA_W;

  logic [PW-1:0] pp_row  [DATA_W];
  logic [PW-1:0] row_sum [DATA_W];

  for (genvar i = 0; i < DATA_W; i++) begin : g_row
    logic [PW-1:0] a_ext;
    assign a_ext     = {{DATA_W{1'b0}}, (a & {DATA_W{b[i]}})};
    assign pp_row[i] = a_ext << i;

    if (i == 0) begin : g_first
      assign row_sum[i] = pp_row[i];
    end else begin : g_chain
      // The running sum never exceeds PW bits because the final result
      // (2^DATA_W-1)^2 fits, so dropping the carry is exact.
      assign row_sum[i] = row_sum[i-1] + pp_row[i];
    end
  end

  assign prod = row_sum[DATA_W-1];

endmodule

// File: rtl/mac_unit.sv
// Unsigned multiply-accumulate: every rising edge outside reset adds a*b into
// the accumulator, wrapping modulo 2^ACC_W and raising a sticky overflow flag.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears acc and ovf immediately
//   a   : unsigned multiplicand, DATA_W bits
//   b   : unsigned multiplier, DATA_W bits
//   acc : registered accumulator value, ACC_W bits
//   ovf : sticky flag, set once any accumulation wraps past 2^ACC_W-1
// ACC_W must be at least 2*DATA_W so a single product never truncates.
module mac_unit #(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int ACC_W  = mac_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);
  import mac_pkg::*;

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      sum_ext;
  logic [ACC_W-1:0]    acc_d, acc_q;
  logic                ovf_d, ovf_q;

  mac_mult #(.DATA_W(DATA_W)) u_mult (
    .a    (a),
    .b    (b),
    .prod (prod)
  );

  // One extra bit on the adder: its carry-out is exactly the wrap condition.
  assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - 2*DATA_W){1'b0}}, prod};

  always_comb begin
    acc_d = sum_ext[ACC_W-1:0];
    ovf_d = ovf_q | sum_ext[ACC_W];
  end

  // Accumulator register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_mac_unit.sv
// Scoreboard bench for mac_unit: the driver predicts each accumulation with
// plain integer arithmetic and queues the expected {ovf, acc}; a monitor pops
// and compares after every non-reset clock edge.
module tb_mac_unit;
  import mac_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b0;
  operand_t a = '0;
  operand_t b = '0;
  acc_t     acc;
  logic     ovf;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers).
  int model_acc = 0;
  bit model_ovf = 1'b0;

  typedef struct {
    int acc;
    bit ovf;
  } exp_t;
  exp_t exp_q[$];

  mac_unit dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .acc (acc),
    .ovf (ovf)
  );

  always #5 clk = ~clk;

  // Predict what the next edge produces and queue it.
  function automatic void model_step(input int av, input int bv);
    exp_t e;
    int   sum;
    sum = model_acc + av * bv;
    if (sum >= 65536) model_ovf = 1'b1;
    model_acc = sum % 65536;
    e.acc = model_acc;
    e.ovf = model_ovf;
    exp_q.push_back(e);
  endfunction

  task automatic check_reset(input string name);
    checks++;
    if (acc !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s: got acc=%0d ovf=%0b, expected acc=0 ovf=0", name, acc, ovf);
    end
  endtask

  // Drive operands for the coming edge.
  task automatic cycle(input int av, input int bv);
    @(negedge clk);
    a = operand_t'(av);
    b = operand_t'(bv);
    model_step(av, bv);
  endtask

  // Pulse reset between edges, check outputs clear immediately, then set up
  // operands for the first edge after release.
  task automatic rst_pulse(input int av, input int bv);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("async_reset");
    #1 rst = 1'b0;
    model_acc = 0;
    model_ovf = 1'b0;
    a = operand_t'(av);
    b = operand_t'(bv);
    model_step(av, bv);
  endtask

  // Monitor: every edge outside reset should match the next queued result.
  always @(posedge clk) begin
    if (!rst) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got acc=%0d ovf=%0b with no expected entry", acc, ovf);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (acc !== acc_t'(e.acc) || ovf !== e.ovf) begin
          errors++;
          $display("FAIL acc_ovf: got acc=%0d ovf=%0b, expected acc=%0d ovf=%0b",
                   acc, ovf, e.acc, e.ovf);
        end
      end
    end
  end

  initial begin
    // Initial reset, held across edges with nonzero operands.
    #1 rst = 1'b1;
    #1 check_reset("reset_assert");
    a = 8'd77;
    b = 8'd99;
    #10 check_reset("reset_hold");
    a = '0;
    b = '0;

    // Release on a falling edge; the very next edge accumulates.
    @(negedge clk);
    rst = 1'b0;
    a = 8'd2;
    b = 8'd4;
    model_step(2, 4);            // 8
    cycle(4, 4);                 // 24
    for (int i = 0; i < 5; i++) cycle(0, 200);  // holds 24
    cycle(3, 5);                 // 39
    cycle(3, 5);                 // 54

    // Async reset mid-run, then 1*1 -> 1.
    rst_pulse(1, 1);
    cycle(7, 9);

    // Max product and overflow wrap.
    rst_pulse(255, 255);         // 65025, no overflow
    cycle(255, 2);               // 65535, no overflow
    cycle(1, 1);                 // wraps to 0, ovf set
    cycle(3, 3);                 // 9, ovf stays set
    cycle(0, 0);                 // 9, ovf stays set

    // Random regression with occasional reset pulses.
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 29) == 0)
        rst_pulse(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      else
        cycle(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    // Let the last queued result be consumed.
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
